gf2m_digit_mult: RTL and testbench

- Parametrised, iterative GF(2)[x] multiplier. Successor to the fixed-width combinational Karatsuba multipliers in the gf_571 datapath.
- Processes operand b one DIGIT-bit slice per cycle, MSB-first.
- Per-operation mode selects one of two results:
  - unreduced 2*WIDTH-bit product;
  - product reduced modulo the field polynomial x^WIDTH + POLY.
- Sits between the point-arithmetic sequencer and the register file. Valid/ready handshake on both sides.

---
 rtl/gf2m_digit_mult_if.sv | 34 +++
 rtl/gf2m_digit_mult.sv | 190 +++++++++++++++++++
 tb/tb_gf2m_digit_mult.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gf2m_digit_mult_if.sv
// ---------------------------------------------------------------------------
// gf2m_digit_mult_if
//   Handshake bundle between the point-arithmetic sequencer (master) and the
//   digit-serial GF(2)[x] multiplier (slave).
//
//   Request side : in_valid, in_ready, a, b, reduce_en
//   Result side  : out_valid, out_ready, d
//
//   WIDTH : operand width / field degree m. d is 2*WIDTH bits wide.
// ---------------------------------------------------------------------------
interface gf2m_digit_mult_if #(
    parameter int unsigned WIDTH = 571
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 reduce_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   d;

    // Sequencer side: issues operations, consumes results.
    modport master (
        output in_valid, a, b, reduce_en, out_ready,
        input  in_ready, out_valid, d
    );

    // Multiplier side.
    modport slave (
        input  in_valid, a, b, reduce_en, out_ready,
        output in_ready, out_valid, d
    );
endinterface

// File: rtl/gf2m_digit_mult.sv
// ---------------------------------------------------------------------------
// gf2m_digit_mult
//   Iterative carry-less (GF(2)[x]) multiplier. Operand b is consumed one
//   DIGIT-bit slice per cycle, most significant digit first. Each operation
//   selects either the unreduced 2*WIDTH-bit product or the product reduced
//   modulo x^WIDTH + POLY.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, aborts any operation in flight
//   mul_if : slave modport of gf2m_digit_mult_if
//              in_valid/in_ready   accept a, b, reduce_en (IDLE only)
//              out_valid/out_ready hand over d (held stable until taken)
//
// Parameters
//   WIDTH : operand width / field degree m
//   DIGIT : bits of b per cycle, 1..WIDTH
//   POLY  : field polynomial tail, degree must be < WIDTH-DIGIT
// ---------------------------------------------------------------------------
module gf2m_digit_mult #(
    parameter int unsigned      WIDTH = 571,
    parameter int unsigned      DIGIT = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(11'h425)
) (
    input  logic             clk,
    input  logic             rst_n,
    gf2m_digit_mult_if.slave mul_if
);

    localparam int unsigned NDIG  = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int unsigned BW    = NDIG * DIGIT;        // padded b width
    localparam int unsigned TW    = WIDTH + DIGIT - 1;   // a * digit width
    localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic int poly_deg(input logic [WIDTH-1:0] p);
        int deg;
        deg = -1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (p[i]) deg = i;
        end
        return deg;
    endfunction

    // Carry-less product of the full multiplicand with one digit of b.
    function automatic logic [TW-1:0] clmul_digit(input logic [WIDTH-1:0] x,
                                                  input logic [DIGIT-1:0] y);
        logic [TW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            if (y[i]) r = r ^ (TW'(x) << i);
        end
        return r;
    endfunction

    // Replace every bit of weight x^(WIDTH+k) by POLY*x^k. Because POLY has
    // degree < WIDTH-DIGIT, POLY*x^k stays below x^WIDTH, so one pass leaves
    // a fully reduced value.
    function automatic logic [WIDTH-1:0] fold(input logic [WIDTH+DIGIT-1:0] v);
        logic [WIDTH-1:0] r;
        r = v[WIDTH-1:0];
        for (int k = 0; k < int'(DIGIT); k++) begin
            if (v[WIDTH+k]) r = r ^ (POLY << k);
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
        $error("gf2m_digit_mult: DIGIT must lie in 1..WIDTH");
    end
    if (poly_deg(POLY) >= int'(WIDTH) - int'(DIGIT)) begin : g_bad_poly
        $error("gf2m_digit_mult: degree of POLY must be below WIDTH-DIGIT");
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e              state_q,  state_d;
    logic [WIDTH-1:0]    a_q,      a_d;
    logic [BW-1:0]       b_q,      b_d;
    logic                reduce_q, reduce_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [2*WIDTH-1:0]  acc_q,    acc_d;
    logic [2*WIDTH-1:0]  d_q,      d_d;

    // -----------------------------------------------------------------------
    // Datapath: one digit step of the Horner accumulation
    // -----------------------------------------------------------------------
    logic [DIGIT-1:0]       digit;
    logic [TW-1:0]          part;
    logic [2*WIDTH-1:0]     acc_unred;
    logic [WIDTH+DIGIT-1:0] acc_wide;
    logic [2*WIDTH-1:0]     acc_next;

    always_comb begin
        digit     = b_q[int'(cnt_q) * DIGIT +: DIGIT];
        part      = clmul_digit(a_q, digit);
        acc_unred = (acc_q << DIGIT) ^ (2*WIDTH)'(part);
        // Reduced mode only ever holds WIDTH live bits in the accumulator.
        acc_wide  = {acc_q[WIDTH-1:0], {DIGIT{1'b0}}} ^ (WIDTH+DIGIT)'(part);
        acc_next  = reduce_q ? (2*WIDTH)'(fold(acc_wide)) : acc_unred;
    end

    // -----------------------------------------------------------------------
    // Control: next-state and register updates
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        reduce_d = reduce_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        d_d      = d_q;

        unique case (state_q)
            S_IDLE: begin
                if (mul_if.in_valid) begin
                    a_d      = mul_if.a;
                    b_d      = BW'(mul_if.b);
                    reduce_d = mul_if.reduce_en;
                    acc_d    = '0;
                    cnt_d    = CNT_LAST;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_d = acc_next;
                if (cnt_q == '0) begin
                    d_d     = acc_next;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                // No new acceptance in the consuming cycle: IDLE is entered first.
                if (mul_if.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand and accumulator registers are cleared too, so an
            // aborted operation leaves nothing behind that a later one could see.
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            reduce_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            d_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            reduce_q <= reduce_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            d_q      <= d_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs are decoded straight from the state register so that reset
    // forces them immediately.
    // -----------------------------------------------------------------------
    assign mul_if.in_ready  = (state_q == S_IDLE);
    assign mul_if.out_valid = (state_q == S_DONE);
    assign mul_if.d         = d_q;

endmodule

// File: tb/tb_gf2m_digit_mult.sv
// ---------------------------------------------------------------------------
// tb_gf2m_digit_mult
//   Drives two instances: a small one (WIDTH=8, DIGIT=3, POLY=0x1B) and the
//   full-size one (WIDTH=571, DIGIT=16, POLY=0x425). Expected results are
//   queued when an operation is issued and compared when the result handshake
//   completes. The reference is a plain bit-serial carry-less multiply plus
//   long-division reduction.
// ---------------------------------------------------------------------------
module tb_gf2m_digit_mult;

    localparam int SW     = 8;
    localparam int SD     = 3;
    localparam int S_NDIG = 3;
    localparam int LW     = 571;
    localparam int LD     = 16;
    localparam int L_NDIG = 36;

    typedef logic [2*LW-1:0] wide_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    gf2m_digit_mult_if #(.WIDTH(SW)) bs ();
    gf2m_digit_mult_if #(.WIDTH(LW)) bl ();

    gf2m_digit_mult #(.WIDTH(SW), .DIGIT(SD), .POLY(8'h1B)) u_dut_s (
        .clk    (clk),
        .rst_n  (rst_n),
        .mul_if (bs.slave)
    );

    gf2m_digit_mult #(.WIDTH(LW), .DIGIT(LD), .POLY(571'h425)) u_dut_l (
        .clk    (clk),
        .rst_n  (rst_n),
        .mul_if (bl.slave)
    );

    int    n_cmp = 0;
    int    n_err = 0;
    wide_t q_s[$];
    wide_t q_l[$];

    // -----------------------------------------------------------------------
    // Checking and reference model
    // -----------------------------------------------------------------------
    task automatic check(input string tag, input wide_t obs, input wide_t exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got (low 256b) %0h, expected (low 256b) %0h",
                     tag, obs[255:0], exp[255:0]);
        end
    endtask

    function automatic wide_t clmul_ref(input wide_t x, input wide_t y, input int w);
        wide_t r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            if (y[i]) r = r ^ (x << i);
        end
        return r;
    endfunction

    function automatic wide_t reduce_ref(input wide_t v, input wide_t poly, input int w);
        wide_t p;
        p = poly | (wide_t'(1) << w);
        for (int i = 2 * w - 1; i >= w; i--) begin
            if (v[i]) v = v ^ (p << (i - w));
        end
        return v;
    endfunction

    function automatic logic [LW-1:0] rand_l();
        logic [18*32-1:0] r;
        for (int i = 0; i < 18; i++) r[i*32 +: 32] = $urandom;
        return r[LW-1:0];
    endfunction

    // -----------------------------------------------------------------------
    // Scoreboard monitors: a result is taken on the edge after this negedge
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n && bs.out_valid && bs.out_ready) begin
            if (q_s.size() == 0) check("s_spurious_out", wide_t'(bs.out_valid), '0);
            else                 check("s_result", wide_t'(bs.d), q_s.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && bl.out_valid && bl.out_ready) begin
            if (q_l.size() == 0) check("l_spurious_out", wide_t'(bl.out_valid), '0);
            else                 check("l_result", wide_t'(bl.d), q_l.pop_front());
        end
    end

    // -----------------------------------------------------------------------
    // Drivers
    // -----------------------------------------------------------------------
    task automatic wait_s_ready(input string tag);
        int n;
        n = 0;
        while (!bs.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_in_ready"}, wide_t'(bs.in_ready), wide_t'(1));
    endtask

    task automatic wait_l_ready(input string tag);
        int n;
        n = 0;
        while (!bl.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_in_ready"}, wide_t'(bl.in_ready), wide_t'(1));
    endtask

    // Issue one op, queue its expected result, measure latency to out_valid.
    task automatic run_s(input logic [SW-1:0] a, input logic [SW-1:0] b,
                         input logic red, input wide_t exp, input string tag);
        int n;
        bit rdy_seen;
        wait_s_ready(tag);
        @(negedge clk);
        bs.a = a; bs.b = b; bs.reduce_en = red; bs.in_valid = 1'b1;
        q_s.push_back(exp);
        @(posedge clk); #1;
        // Operands may change freely once accepted.
        bs.in_valid = 1'b0; bs.a = ~a; bs.b = ~b; bs.reduce_en = ~red;
        n = 0;
        rdy_seen = 1'b0;
        while (!bs.out_valid && n < 200) begin
            if (bs.in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1; n++;
        end
        check({tag, "_latency"}, wide_t'(n), wide_t'(S_NDIG));
        check({tag, "_in_ready_busy"}, wide_t'(rdy_seen), '0);
    endtask

    task automatic run_l(input logic [LW-1:0] a, input logic [LW-1:0] b,
                         input logic red, input wide_t exp, input string tag);
        int n;
        bit rdy_seen;
        wait_l_ready(tag);
        @(negedge clk);
        bl.a = a; bl.b = b; bl.reduce_en = red; bl.in_valid = 1'b1;
        q_l.push_back(exp);
        @(posedge clk); #1;
        bl.in_valid = 1'b0; bl.a = ~a; bl.b = ~b; bl.reduce_en = ~red;
        n = 0;
        rdy_seen = 1'b0;
        while (!bl.out_valid && n < 200) begin
            if (bl.in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1; n++;
        end
        check({tag, "_latency"}, wide_t'(n), wide_t'(L_NDIG));
        check({tag, "_in_ready_busy"}, wide_t'(rdy_seen), '0);
    endtask

    task automatic run_s_model(input logic [SW-1:0] a, input logic [SW-1:0] b,
                               input logic red, input string tag);
        wide_t exp;
        exp = clmul_ref(wide_t'(a), wide_t'(b), SW);
        if (red) exp = reduce_ref(exp, wide_t'(8'h1B), SW);
        run_s(a, b, red, exp, tag);
    endtask

    task automatic run_l_model(input logic [LW-1:0] a, input logic [LW-1:0] b,
                               input logic red, input string tag);
        wide_t exp;
        exp = clmul_ref(wide_t'(a), wide_t'(b), LW);
        if (red) exp = reduce_ref(exp, wide_t'(11'h425), LW);
        run_l(a, b, red, exp, tag);
    endtask

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    initial begin
        bit ov_bad;
        bit d_bad;

        bs.in_valid = 1'b0; bs.a = '0; bs.b = '0; bs.reduce_en = 1'b0; bs.out_ready = 1'b1;
        bl.in_valid = 1'b0; bl.a = '0; bl.b = '0; bl.reduce_en = 1'b0; bl.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("s_reset_in_ready",  wide_t'(bs.in_ready),  wide_t'(1));
        check("s_reset_out_valid", wide_t'(bs.out_valid), '0);
        check("s_reset_d",         wide_t'(bs.d),         '0);
        check("l_reset_in_ready",  wide_t'(bl.in_ready),  wide_t'(1));
        check("l_reset_out_valid", wide_t'(bl.out_valid), '0);
        #2 rst_n = 1'b1;

        // Small instance: directed vectors.
        run_s(8'h53, 8'hCA, 1'b0, wide_t'(16'h3F7E), "s_unred");
        run_s(8'h53, 8'hCA, 1'b1, wide_t'(16'h0001), "s_red");
        run_s(8'h00, 8'hFF, 1'b1, '0,                "s_zero_a");
        run_s(8'hFF, 8'h00, 1'b0, '0,                "s_zero_b");
        run_s(8'hFF, 8'hFF, 1'b0, wide_t'(16'h5555), "s_all_ones");

        // Small instance: random, both modes.
        for (int i = 0; i < 8; i++) begin
            run_s_model(8'($urandom), 8'($urandom), 1'(i), "s_rand");
        end

        // Large instance: directed vectors.
        run_l(LW'(1) << 570, LW'(2), 1'b1, wide_t'(11'h425),     "l_red_x571");
        run_l(LW'(1) << 570, LW'(2), 1'b0, wide_t'(1) << 571,    "l_unred_x571");
        run_l('0, rand_l(), 1'b0, '0,                            "l_zero_a");

        // Large instance: random, both modes; last one leaves d nonzero.
        for (int i = 0; i < 6; i++) begin
            run_l_model(rand_l(), rand_l(), 1'(i), "l_rand");
        end

        // Back-pressure: result held while out_ready is low, inputs ignored.
        bs.out_ready = 1'b0;
        run_s(8'h53, 8'hCA, 1'b0, wide_t'(16'h3F7E), "s_bp");
        ov_bad = 1'b0;
        d_bad  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bs.in_valid  = i[0];
            bs.a         = 8'($urandom);
            bs.b         = 8'($urandom);
            bs.reduce_en = i[1];
            @(posedge clk); #1;
            if (bs.out_valid !== 1'b1) ov_bad = 1'b1;
            if (bs.d !== 16'h3F7E)     d_bad  = 1'b1;
        end
        bs.in_valid = 1'b0;
        check("s_bp_valid_held", wide_t'(ov_bad), '0);
        check("s_bp_d_held",     wide_t'(d_bad),  '0);
        bs.out_ready = 1'b1;
        @(posedge clk); #1;
        check("s_bp_release_valid", wide_t'(bs.out_valid), '0);
        check("s_bp_release_ready", wide_t'(bs.in_ready),  wide_t'(1));
        repeat (3) @(posedge clk);
        #1;
        check("s_bp_no_stray_accept", wide_t'(bs.in_ready), wide_t'(1));

        // Asynchronous reset in the middle of BUSY aborts the operation.
        @(negedge clk);
        bs.a = 8'h53; bs.b = 8'hCA; bs.reduce_en = 1'b1; bs.in_valid = 1'b1;
        @(posedge clk); #1;
        bs.in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("s_arst_in_ready",  wide_t'(bs.in_ready),  wide_t'(1));
        check("s_arst_out_valid", wide_t'(bs.out_valid), '0);
        check("s_arst_d",         wide_t'(bs.d),         '0);
        check("l_arst_d",         wide_t'(bl.d),         '0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_s(8'h53, 8'hCA, 1'b1, wide_t'(16'h0001), "s_after_rst");
        run_s(8'h53, 8'hCA, 1'b0, wide_t'(16'h3F7E), "s_after_rst_unred");

        // Drain and confirm nothing is left outstanding.
        repeat (4) @(posedge clk);
        #1;
        check("s_queue_empty", wide_t'(q_s.size()), '0);
        check("l_queue_empty", wide_t'(q_l.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
